// File: rtl/non_restoring_divider.sv
// Multi-cycle non-restoring integer divider with start/busy/done handshake,
// optional two's-complement operands, divide-by-zero status and remainder correction.
module non_restoring_divider #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH:0]   acc;       // signed partial remainder A
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] d_reg;
   logic [WIDTH-1:0] dvd_raw;   // untouched dividend, reported as remainder on divide-by-zero
   logic             neg_q;
   logic             neg_r;
   logic             zero_div;

   logic             dvd_neg;
   logic             dvs_neg;
   logic [WIDTH-1:0] dvd_mag;
   logic [WIDTH-1:0] dvs_mag;
   logic [WIDTH:0]   d_ext;
   logic [WIDTH:0]   acc_sh;
   logic [WIDTH:0]   acc_next;
   logic [WIDTH:0]   acc_fix;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;

   always_comb begin
      // NOTE: every combinational output gets a value on every path so no latch is inferred.
      dvd_neg  = signed_mode & dividend[WIDTH-1];
      dvs_neg  = signed_mode & divisor[WIDTH-1];
      // Magnitudes are unsigned WIDTH-bit, so the most negative value maps to 2^(WIDTH-1).
      dvd_mag  = dvd_neg ? -dividend : dividend;
      dvs_mag  = dvs_neg ? -divisor  : divisor;
      d_ext    = {1'b0, d_reg};
      acc_sh   = {acc[WIDTH-1:0], q_reg[WIDTH-1]};
      acc_next = acc[WIDTH] ? acc_sh + d_ext : acc_sh - d_ext;
      acc_fix  = acc[WIDTH] ? acc + d_ext : acc;
      q_fix    = neg_q ? -q_reg : q_reg;
      r_fix    = neg_r ? -acc_fix[WIDTH-1:0] : acc_fix[WIDTH-1:0];
   end

   // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         cnt         <= '0;
         acc         <= '0;
         q_reg       <= '0;
         d_reg       <= '0;
         dvd_raw     <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         zero_div    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  q_reg    <= dvd_mag;
                  d_reg    <= dvs_mag;
                  dvd_raw  <= dividend;
                  neg_q    <= dvd_neg ^ dvs_neg;
                  neg_r    <= dvd_neg;
                  zero_div <= (divisor == '0);
                  acc      <= '0;
                  cnt      <= '0;
                  busy     <= 1'b1;
                  state    <= (divisor == '0) ? FIX : RUN;
               end
            end
            RUN: begin
               acc   <= acc_next;
               q_reg <= {q_reg[WIDTH-2:0], ~acc_next[WIDTH]};
               cnt   <= cnt + 1'b1;
               if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
            end
            FIX: begin
               acc <= acc_fix;
               if (zero_div) begin
                  quotient  <= '1;
                  remainder <= dvd_raw;
               end else begin
                  quotient  <= q_fix;
                  remainder <= r_fix;
               end
               div_by_zero <= zero_div;
               done        <= 1'b1;
               busy        <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_non_restoring_divider.sv
// Scoreboard bench for non_restoring_divider: a 16-bit and an 8-bit instance
// checked against an integer-arithmetic reference model.
module tb_non_restoring_divider;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   always #5 clk = ~clk;

   logic        start16 = 1'b0, sm16 = 1'b0;
   logic [15:0] dvd16 = '0, dvs16 = '0;
   logic        busy16, done16, dbz16;
   logic [15:0] quo16, rem16;

   logic        start8 = 1'b0, sm8 = 1'b0;
   logic [7:0]  dvd8 = '0, dvs8 = '0;
   logic        busy8, done8, dbz8;
   logic [7:0]  quo8, rem8;

   non_restoring_divider #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
      .dividend(dvd16), .divisor(dvs16), .busy(busy16), .done(done16),
      .quotient(quo16), .remainder(rem16), .div_by_zero(dbz16)
   );

   non_restoring_divider #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
      .dividend(dvd8), .divisor(dvs8), .busy(busy8), .done(done8),
      .quotient(quo8), .remainder(rem8), .div_by_zero(dbz8)
   );

   typedef struct packed {
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
   } exp_t;

   exp_t sb16[$];
   exp_t sb8[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic exp_t model(input int w, input logic sm,
                                  input logic [31:0] a, input logic [31:0] b);
      exp_t   e;
      longint mask, sa, sb, qq, rr;
      mask = (longint'(1) << w) - 1;
      sa   = longint'(a) & mask;
      sb   = longint'(b) & mask;
      if (sb == 0) begin
         e.q = 32'(mask); e.r = 32'(sa); e.dbz = 1'b1;
         return e;
      end
      if (sm) begin
         if (sa[w-1]) sa = sa - (longint'(1) << w);
         if (sb[w-1]) sb = sb - (longint'(1) << w);
      end
      qq = sa / sb;
      rr = sa % sb;
      e.q = 32'(qq & mask); e.r = 32'(rr & mask); e.dbz = 1'b0;
      return e;
   endfunction

   // Drive a request, push its expected result, pass the accept edge, then scramble operands.
   task automatic issue(input int w, input logic sm, input logic [31:0] a, input logic [31:0] b);
      if (w == 16) begin
         sb16.push_back(model(16, sm, a, b));
         start16 = 1'b1; sm16 = sm; dvd16 = a[15:0]; dvs16 = b[15:0];
      end else begin
         sb8.push_back(model(8, sm, a, b));
         start8 = 1'b1; sm8 = sm; dvd8 = a[7:0]; dvs8 = b[7:0];
      end
      @(posedge clk);
      #1;
      if (w == 16) begin
         start16 = 1'b0; sm16 = ~sm; dvd16 = 16'($urandom); dvs16 = 16'($urandom);
      end else begin
         start8 = 1'b0; sm8 = ~sm; dvd8 = 8'($urandom); dvs8 = 8'($urandom);
      end
   endtask

   // Wait (bounded) for done, checking busy meanwhile, then pop and compare.
   task automatic await(input int w, input int lat, input string name);
      exp_t        e;
      int          seen;
      logic        got;
      logic        ob, odn, od;
      logic [31:0] oq, orm;
      got  = 1'b0;
      seen = -1;
      for (int i = 0; i <= lat + 4; i++) begin
         @(negedge clk);
         odn = (w == 16) ? done16 : done8;
         ob  = (w == 16) ? busy16 : busy8;
         if (odn) begin
            got  = 1'b1;
            seen = i;
            break;
         end
         checks++;
         if (ob !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_before_done cycle=%0d got=%b want=1", name, i, ob);
         end
      end
      if (w == 16) e = (sb16.size() > 0) ? sb16.pop_front() : '0;
      else         e = (sb8.size() > 0)  ? sb8.pop_front()  : '0;
      checks++;
      if (!got) begin
         failures++;
         $display("FAIL %s timeout got=no_done want=done_after_%0d_edges", name, lat);
         return;
      end
      oq  = (w == 16) ? 32'(quo16) : 32'(quo8);
      orm = (w == 16) ? 32'(rem16) : 32'(rem8);
      od  = (w == 16) ? dbz16 : dbz8;
      ob  = (w == 16) ? busy16 : busy8;
      if (seen != lat) begin
         failures++;
         $display("FAIL %s latency got=%0d want=%0d", name, seen, lat);
      end
      checks++;
      if (ob !== 1'b0) begin
         failures++;
         $display("FAIL %s busy_at_done got=%b want=0", name, ob);
      end
      checks++;
      if (oq !== e.q) begin
         failures++;
         $display("FAIL %s quotient got=%h want=%h", name, oq, e.q);
      end
      checks++;
      if (orm !== e.r) begin
         failures++;
         $display("FAIL %s remainder got=%h want=%h", name, orm, e.r);
      end
      checks++;
      if (od !== e.dbz) begin
         failures++;
         $display("FAIL %s div_by_zero got=%b want=%b", name, od, e.dbz);
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({busy16, done16, quo16, rem16, dbz16, busy8, done8, quo8, rem8, dbz8} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got=%h/%h/%b/%b want=0", quo16, rem16, busy16, done16);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_unsigned_basic();
      issue(16, 1'b0, 100, 7);
      await(16, 17, "u100_7");
      checks++;
      if (quo16 !== 16'd14 || rem16 !== 16'd2) begin
         failures++;
         $display("FAIL u100_7_const got=%0d,%0d want=14,2", quo16, rem16);
      end
      @(negedge clk);
      checks++;
      if (done16 !== 1'b0) begin
         failures++;
         $display("FAIL done_width got=%b want=0", done16);
      end
   endtask

   task automatic test_signed();
      issue(16, 1'b1, 32'hFF9C, 7);
      await(16, 17, "s_m100_7");
      checks++;
      if (quo16 !== 16'hFFF2 || rem16 !== 16'hFFFE) begin
         failures++;
         $display("FAIL s_m100_7_const got=%h,%h want=fff2,fffe", quo16, rem16);
      end
      @(negedge clk);
      issue(16, 1'b1, 100, 32'hFFF9);
      await(16, 17, "s_100_m7");
      @(negedge clk);
      issue(16, 1'b1, 32'hFF9C, 32'hFFF9);
      await(16, 17, "s_m100_m7");
   endtask

   task automatic test_div_zero();
      @(negedge clk);
      issue(16, 1'b0, 1234, 0);
      await(16, 1, "dbz_u");
      checks++;
      if (quo16 !== 16'hFFFF || rem16 !== 16'd1234 || dbz16 !== 1'b1) begin
         failures++;
         $display("FAIL dbz_const got=%h,%0d,%b want=ffff,1234,1", quo16, rem16, dbz16);
      end
      @(negedge clk);
      issue(16, 1'b1, 32'h8001, 0);
      await(16, 1, "dbz_s");
      @(negedge clk);
      issue(16, 1'b0, 999, 10);
      await(16, 17, "dbz_clear");
   endtask

   task automatic test_overflow();
      @(negedge clk);
      issue(16, 1'b1, 32'h8000, 32'hFFFF);
      await(16, 17, "s_ovf");
      checks++;
      if (quo16 !== 16'h8000 || rem16 !== 16'h0000 || dbz16 !== 1'b0) begin
         failures++;
         $display("FAIL s_ovf_const got=%h,%h,%b want=8000,0000,0", quo16, rem16, dbz16);
      end
      @(negedge clk);
      issue(16, 1'b0, 32'hFFFF, 1);
      await(16, 17, "u_full");
      @(negedge clk);
      issue(16, 1'b0, 32'h1234, 32'hFFFF);
      await(16, 17, "u_small_by_max");
   endtask

   task automatic test_random();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         issue(16, 1'(i % 2), $urandom & 32'hFFFF, ($urandom_range(1, 16'hFFFF)) >> (i % 13));
         await(16, ((dvs16 == 0) ? 17 : 17), $sformatf("rand16_%0d", i));
      end
   endtask

   task automatic test_ignore_start();
      logic seen;
      @(negedge clk);
      issue(16, 1'b0, 5000, 3);
      repeat (2) @(negedge clk);
      start16 = 1'b1; sm16 = 1'b1; dvd16 = 16'd9; dvs16 = 16'd2;
      @(negedge clk);
      start16 = 1'b0;
      await(16, 14, "ignore_busy_start");
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (done16) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         failures++;
         $display("FAIL ignore_no_extra_done got=%b want=0", seen);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      issue(16, 1'b1, 32'hFED4, 17);
      await(16, 17, "b2b_first");
      issue(16, 1'b0, 60000, 7);
      await(16, 17, "b2b_second");
   endtask

   task automatic test_reset_mid();
      logic seen;
      @(negedge clk);
      issue(16, 1'b0, 4321, 5);
      repeat (8) @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if ({busy16, done16, quo16, rem16, dbz16} !== '0) begin
         failures++;
         $display("FAIL reset_mid_outputs got=%b,%b,%h,%h,%b want=0", busy16, done16, quo16, rem16, dbz16);
      end
      sb16.delete();
      @(negedge clk);
      rst = 1'b1;
      seen = 1'b0;
      repeat (25) begin
         @(negedge clk);
         if (done16) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_no_done got=%b want=0", seen);
      end
   endtask

   task automatic test_width8();
      @(negedge clk);
      issue(8, 1'b0, 255, 16);
      await(8, 9, "w8_u255_16");
      checks++;
      if (quo8 !== 8'd15 || rem8 !== 8'd15) begin
         failures++;
         $display("FAIL w8_u255_16_const got=%0d,%0d want=15,15", quo8, rem8);
      end
      @(negedge clk);
      issue(8, 1'b1, 32'h80, 3);
      await(8, 9, "w8_s_m128_3");
      checks++;
      if (quo8 !== 8'hD6 || rem8 !== 8'hFE) begin
         failures++;
         $display("FAIL w8_s_m128_3_const got=%h,%h want=d6,fe", quo8, rem8);
      end
      @(negedge clk);
      issue(8, 1'b1, 32'h80, 32'hFF);
      await(8, 9, "w8_s_ovf");
      @(negedge clk);
      issue(8, 1'b0, 77, 0);
      await(8, 1, "w8_dbz");
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         issue(8, 1'(i % 2), $urandom & 32'hFF, $urandom_range(1, 255));
         await(8, 9, $sformatf("rand8_%0d", i));
      end
   endtask

   initial begin
      test_reset();
      test_unsigned_basic();
      test_signed();
      test_div_zero();
      test_overflow();
      test_random();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      test_width8();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
